// File: rtl/rom_page_loader.sv
// rom_page_loader: maps the ioctl download stream onto SDRAM boot writes and tracks loaded ROM pages
module rom_page_loader #(
  parameter int          PAGE_BITS  = 8,
  parameter int          NUM_BANKS  = 2,
  parameter logic [35:0] SYS_MAP    = {9'h1FF, 9'h107, 9'h100, 9'h000},
  parameter logic [8:0]  COMBO_PAGE = '1,
  parameter logic [8:0]  BAD_PAGE   = 9'h1EE,
  localparam int         BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic [15:0]          ioctl_file_ext,
  input  logic [BW-1:0]        model_bank,
  input  logic                 map_clear,
  input  logic [PAGE_BITS-1:0] query_page,
  output logic                 boot_wr,
  output logic [PAGE_BITS+14:0] boot_a,
  output logic [BW-1:0]        boot_bank,
  output logic [7:0]           boot_dout,
  output logic                 query_hit,
  output logic [PAGE_BITS:0]   pages_loaded,
  output logic                 overflow,
  output logic                 busy
);
  localparam int N = 1 << PAGE_BITS;
  localparam logic [PAGE_BITS:0] FULL = (PAGE_BITS + 1)'(N);
  localparam logic [10:0] SLOTS = 11'(4 * NUM_BANKS);
  logic [8:0] r_page;
  logic r_combo, r_dl_d, r_wr_d, r_busy, r_pend;
  logic [PAGE_BITS-1:0] r_base, r_ptr;
  logic [N-1:0] r_map;
  logic [4:0] w_hi, w_lo;
  logic [8:0] w_new_page, w_sys;
  logic w_z, w_start, w_wr, w_wr_fall, w_clear, w_stale, w_set;
  logic [10:0] w_slot;
  logic [PAGE_BITS-1:0] w_rel, w_idx;
  logic [PAGE_BITS:0] w_sum;
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    return (c >= "0" && c <= "9") ? {1'b1, 4'(c - "0")} :
           (c >= "A" && c <= "F") ? {1'b1, 4'(c - "7")} : 5'd0;
  endfunction
  assign w_hi = hex_nib(ioctl_file_ext[15:8]);
  assign w_lo = hex_nib(ioctl_file_ext[7:0]);
  assign w_z = ioctl_file_ext[15:8] == "Z";
  assign w_new_page = (w_z && (ioctl_file_ext[7:0] == "Z" || ioctl_file_ext[7:0] == "0")) ? 9'h000 :
                      {BAD_PAGE[8] | w_hi[4] | w_lo[4], w_hi[4] ? w_hi[3:0] : BAD_PAGE[7:4],
                       w_lo[4] ? w_lo[3:0] : BAD_PAGE[3:0]};
  assign w_start = ioctl_download & ~r_dl_d;
  assign w_wr = ioctl_download & ioctl_wr;
  assign w_wr_fall = ioctl_download & r_wr_d & ~ioctl_wr;
  assign w_clear = r_pend | (map_clear & ~ioctl_download & ~r_busy);
  assign w_slot = ioctl_addr[24:14];
  assign w_sys = SYS_MAP[9*w_slot[1:0] +: 9];
  // r_base lets a combo file restart its page offset at the second 16 KB block
  assign w_rel = ioctl_addr[14 +: PAGE_BITS] - r_base;
  assign w_sum = {1'b0, PAGE_BITS'(r_page[7:0])} + {1'b0, w_rel};
  assign w_idx = boot_a[14 +: PAGE_BITS];
  // entries at or ahead of the sweep pointer hold stale bits and count as empty
  assign w_stale = r_busy & (w_idx >= r_ptr);
  assign w_set = w_wr_fall & boot_a[PAGE_BITS+14] & (~r_map[w_idx] | w_stale);
  assign busy = r_busy;
  // Edge detection and page latch at download start, combo switch at end of first 16 KB
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dl_d <= 1'b0;
      r_wr_d <= 1'b0;
      r_page <= BAD_PAGE;
      r_combo <= 1'b0;
      r_base <= '0;
    end else begin
      r_dl_d <= ioctl_download;
      r_wr_d <= ioctl_wr;
      if (w_start) begin
        r_page <= w_new_page;
        r_combo <= w_z && ioctl_file_ext[7:0] == "0";
        r_base <= '0;
      end else if (w_wr_fall && r_combo && &ioctl_addr[13:0]) begin
        r_combo <= 1'b0;
        r_page <= COMBO_PAGE;
        r_base <= ioctl_addr[14 +: PAGE_BITS] + 1'b1;
      end
    end
  end
  // Registered SDRAM write path for firmware and expansion files
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      boot_wr <= 1'b0;
      boot_a <= '0;
      boot_bank <= '0;
      boot_dout <= '0;
    end else begin
      boot_wr <= 1'b0;
      if (w_wr && ioctl_index == 8'd0) begin
        if (w_slot < SLOTS) begin
          boot_wr <= 1'b1;
          boot_a <= (PAGE_BITS + 15)'({w_sys, ioctl_addr[13:0]});
          boot_bank <= BW'(w_slot >> 2);
          boot_dout <= ioctl_dout;
        end
      end else if (w_wr) begin
        boot_wr <= 1'b1;
        boot_a <= {r_page[8], w_sum[PAGE_BITS-1:0], ioctl_addr[13:0]};
        boot_bank <= model_bank;
        boot_dout <= ioctl_dout;
      end
    end
  end
  // Bitmap sweep/set, loaded-page counter, sticky overflow and registered query
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pend <= 1'b1;
      r_busy <= 1'b0;
      r_ptr <= '0;
      pages_loaded <= '0;
      overflow <= 1'b0;
      query_hit <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      query_hit <= r_map[query_page];
      if (w_clear) begin
        r_busy <= 1'b1;
        r_ptr <= '0;
      end else if (r_busy) begin
        r_map[r_ptr] <= 1'b0;
        r_ptr <= r_ptr + 1'b1;
        r_busy <= ~&r_ptr;
      end
      if (w_set) r_map[w_idx] <= 1'b1;
      if (w_clear) begin
        pages_loaded <= '0;
        overflow <= 1'b0;
      end else begin
        if (w_set && pages_loaded != FULL) pages_loaded <= pages_loaded + 1'b1;
        if (w_wr && ioctl_index != 8'd0 && w_sum[PAGE_BITS]) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_page_loader.sv
// tb_rom_page_loader: directed scoreboard bench for rom_page_loader
module tb_rom_page_loader;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ioctl_download = 1'b0;
  logic [7:0] ioctl_index = '0;
  logic ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic [15:0] ioctl_file_ext = '0;
  logic model_bank = 1'b0;
  logic map_clear = 1'b0;
  logic [7:0] query_page = '0;
  logic boot_wr, query_hit, overflow, busy;
  logic [22:0] boot_a;
  logic boot_bank;
  logic [7:0] boot_dout;
  logic [8:0] pages_loaded;
  int cmp = 0;
  int fails = 0;
  typedef struct packed { logic [22:0] a; logic bank; logic [7:0] d; } exp_t;
  exp_t sb[$];
  rom_page_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_file_ext(ioctl_file_ext),
    .model_bank(model_bank), .map_clear(map_clear), .query_page(query_page), .boot_wr(boot_wr),
    .boot_a(boot_a), .boot_bank(boot_bank), .boot_dout(boot_dout), .query_hit(query_hit),
    .pages_loaded(pages_loaded), .overflow(overflow), .busy(busy)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] data, input logic en,
                         input logic [22:0] a, input logic bank);
    exp_t e;
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr = 1'b1;
    if (en) sb.push_back('{a, bank, data});
    step();
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("boot_wr", 32'(boot_wr), 32'd1);
      chk("boot_a", 32'(boot_a), 32'(e.a));
      chk("boot_bank", 32'(boot_bank), 32'(e.bank));
      chk("boot_dout", 32'(boot_dout), 32'(e.d));
    end else chk("no_wr", 32'(boot_wr), 32'd0);
    step();
    @(negedge clk_sys);
    chk("wr_one_cycle", 32'(boot_wr), 32'd0);
  endtask
  task automatic q(input logic [7:0] p, input logic e, input string tag);
    query_page = p;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk(tag, 32'(query_hit), 32'(e));
  endtask
  task automatic dl_start(input logic [7:0] idx, input logic [15:0] ext);
    ioctl_index = idx;
    ioctl_file_ext = ext;
    ioctl_download = 1'b1;
    repeat (2) step();
  endtask
  task automatic dl_end();
    ioctl_download = 1'b0;
    step();
  endtask
  task automatic do_clear();
    int n;
    map_clear = 1'b1;
    step();
    map_clear = 1'b0;
    @(negedge clk_sys);
    chk("clear_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk("clear_done", 32'(busy), 32'd0);
  endtask
  initial begin
    int n;
    repeat (3) step();
    @(negedge clk_sys);
    chk("rst_boot_wr", 32'(boot_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pages", 32'(pages_loaded), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_qhit", 32'(query_hit), 32'd0);
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (busy) n++;
    end
    chk("busy_cycles", 32'(n), 32'd256);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      query_page = 8'(i);
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (query_hit !== 1'b0) n++;
    end
    chk("map_empty", 32'(n), 32'd0);
    dl_start(8'd0, 16'h0000);
    wr_byte(25'h04005, 8'hA5, 1'b1, 23'h400005, 1'b0);
    wr_byte(25'h14005, 8'h5A, 1'b1, 23'h400005, 1'b1);
    wr_byte(25'h0C123, 8'h3C, 1'b1, 23'h7FC123, 1'b0);
    wr_byte(25'h20000, 8'h77, 1'b0, 23'h0, 1'b0);
    dl_end();
    do_clear();
    chk("fw_clear_pages", 32'(pages_loaded), 32'd0);
    model_bank = 1'b1;
    dl_start(8'd1, 16'h3037);
    wr_byte(25'h00000, 8'h11, 1'b1, 23'h41C000, 1'b1);
    wr_byte(25'h03FFF, 8'h22, 1'b1, 23'h41FFFF, 1'b1);
    wr_byte(25'h04000, 8'h33, 1'b1, 23'h420000, 1'b1);
    wr_byte(25'h07FFF, 8'h44, 1'b1, 23'h423FFF, 1'b1);
    dl_end();
    q(8'h07, 1'b1, "e07_q07");
    q(8'h08, 1'b1, "e07_q08");
    q(8'h09, 1'b0, "e07_q09");
    chk("e07_pages", 32'(pages_loaded), 32'd2);
    chk("e07_ovf", 32'(overflow), 32'd0);
    model_bank = 1'b0;
    dl_start(8'd2, 16'h5A30);
    wr_byte(25'h00000, 8'h55, 1'b1, 23'h000000, 1'b0);
    wr_byte(25'h03FFF, 8'h66, 1'b1, 23'h003FFF, 1'b0);
    wr_byte(25'h04000, 8'h77, 1'b1, 23'h7FC000, 1'b0);
    wr_byte(25'h07FFF, 8'h88, 1'b1, 23'h7FFFFF, 1'b0);
    dl_end();
    q(8'hFF, 1'b1, "z0_qff");
    q(8'h00, 1'b0, "z0_q00");
    chk("z0_pages", 32'(pages_loaded), 32'd3);
    chk("z0_ovf", 32'(overflow), 32'd0);
    dl_start(8'd3, 16'h4646);
    wr_byte(25'h00000, 8'h99, 1'b1, 23'h7FC000, 1'b0);
    wr_byte(25'h04000, 8'hAA, 1'b1, 23'h400000, 1'b0);
    dl_end();
    chk("ff_ovf", 32'(overflow), 32'd1);
    chk("ff_pages", 32'(pages_loaded), 32'd4);
    q(8'h00, 1'b1, "ff_q00");
    do_clear();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_pages", 32'(pages_loaded), 32'd0);
    q(8'h07, 1'b0, "clr_q07");
    q(8'hFF, 1'b0, "clr_qff");
    dl_start(8'd4, 16'h5137);
    wr_byte(25'h00000, 8'hBB, 1'b1, 23'h79C000, 1'b0);
    map_clear = 1'b1;
    step();
    map_clear = 1'b0;
    @(negedge clk_sys);
    chk("q7_clear_ignored", 32'(busy), 32'd0);
    chk("q7_pages", 32'(pages_loaded), 32'd1);
    q(8'hE7, 1'b1, "q7_qe7");
    dl_end();
    wr_byte(25'h04000, 8'hCC, 1'b0, 23'h0, 1'b0);
    chk("q7_pages_held", 32'(pages_loaded), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
